cv_tmdschan: RTL and testbench
==============================

# cv_tmdschan

Per-channel TMDS output formatter, directly downstream of the pipelined data encoder. It re-times the raw control bits (c1, c0) and data-enable by the encoder's pipeline depth. During active video it forwards the encoder's 10-bit word; during blanking it substitutes the matching DVI control token. It also checks that the encoder's output enable and the delayed DE agree, and measures active-run length per line.

## Interface
Parameters:
- LATENCY, 3, encoder pipeline depth in clk cycles (legal 1..8); delay applied to c/de before selection
- LWIDTH, 12, width of active-run counter and line_len

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- cs  in  1  channel enable; 0 forces idle state (same signal as encoder cs)
- c  in  2  control bits {c1,c0}, same timing as encoder din/din_en
- de  in  1  raw data enable, same timing as encoder din_en
- enc_dout  in  10  encoder output word
- enc_dout_en  in  1  encoder output enable
- tmds  out  10  formatted TMDS word, registered
- tmds_de  out  1  registered copy of delayed de used for tmds selection
- align_err  out  1  sticky mismatch flag
- line_len  out  LWIDTH  length of last completed active run
- line_done  out  1  one-cycle pulse when line_len updates

## Operation
- Delay line: c and de each pass through a LATENCY-stage shift register (reset and cs=0 clear all stages to 0). The outputs are c_d and de_d.
- Selection, registered into tmds:
  - cs=0: 10'b1101010100
  - de_d=1: enc_dout
  - de_d=0, c_d=00: 10'b1101010100
  - de_d=0, c_d=01: 10'b0010101011
  - de_d=0, c_d=10: 10'b0101010100
  - de_d=0, c_d=11: 10'b1010101011
- tmds_de <= cs & de_d.
- Alignment check: when cs=1 and de_d != enc_dout_en, set align_err. It remains set until cs=0 or reset. When cs=1, tmds selection follows de_d regardless of the mismatch.
- Run counter (LWIDTH bits):
  - Cleared while de_d=0.
  - Increments each cycle de_d=1, saturating at all-ones; it never wraps.
- On the falling edge of de_d (previous de_d=1, current de_d=0, cs=1):
  - line_len <= counter value + 1, saturating.
  - line_done pulses for exactly 1 cycle, coincident with line_len update.
- Single-cycle active run: gives line_len=1.
- cs falling mid-run: counter clears with no line_done pulse and no line_len update.
- cs rising: delay line starts from zeros. No tmds_de or line_done occurs until a de=1 has propagated LATENCY cycles.

## Timing
- Reset values:
  - tmds = 10'b0
  - tmds_de = 0
  - align_err = 0
  - line_len = 0
  - line_done = 0
  - All delay stages and the run counter = 0
- Latency from c/de input to tmds/tmds_de: LATENCY+1 cycles.
- Latency from enc_dout to tmds: 1 cycle. With LATENCY=3, the word for a pixel presented at din in cycle N appears on tmds in cycle N+4.
- line_done/line_len: registered in the same cycle that tmds shows the first blanking token after the run.
- align_err: asserts 1 cycle after the mismatching cycle.
- cs=0 takes effect on all outputs at the next clock edge, except line_len, which holds.
- Asynchronous reset mid-line: all outputs go to reset values immediately. No pulse is generated on release.

## Test plan
- Reset, then cs=1 and blanking with c=01 held -> from cycle 5 after cs, tmds=0010101011 steady; tmds_de=0; align_err=0.
- Encoder in loop (LATENCY=3): de=1 for 640 cycles with din ramp 0..255 -> tmds equals encoder dout sequence, offset exactly 1 cycle. line_done is a single pulse with line_len=640, coincident with the first blanking token.
- Walk c through 00,01,10,11 during blanking -> tmds tokens 1101010100, 0010101011, 0101010100, 1010101011, each LATENCY+1 cycles after the c change.
- Force enc_dout_en=0 for one cycle inside an active run -> align_err=1 next cycle and held. Pulse cs=0 for 1 cycle -> align_err=0 and tmds=1101010100 during that cycle.
- de=1 for 5000 cycles with LWIDTH=12 -> line_len=4095 (saturated). A single-cycle de pulse afterwards gives line_len=1.
- Drop cs for 1 cycle at pixel 100 of a run -> no line_done pulse. The run counter restarts and the next full run of 200 gives line_len=200. Assert reset mid-run -> all outputs reset immediately.

Source files
------------

// File: rtl/cv_tmdschan.sv
// Per-channel TMDS output formatter: re-times c/de to the encoder pipeline, picks data word or control token.
// Latency: c/de -> tmds is LATENCY+1 cycles; enc_dout -> tmds is 1 cycle.
// Backpressure: none; a free-running pixel stream that is gated only by cs.
module cv_tmdschan #(
    parameter int LATENCY = 3,
    parameter int LWIDTH  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic [1:0]        c,
    input  logic              de,
    input  logic [9:0]        enc_dout,
    input  logic              enc_dout_en,
    output logic [9:0]        tmds,
    output logic              tmds_de,
    output logic              align_err,
    output logic [LWIDTH-1:0] line_len,
    output logic              line_done
);

    // DVI control tokens, indexed by {c1,c0}
    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    localparam logic [LWIDTH-1:0] CNT_ONE = {{(LWIDTH-1){1'b0}}, 1'b1};

    // Shift registers for the raw control bits and data enable; stage 0 is newest
    logic [LATENCY-1:0]      de_sr_q, de_sr_d;
    logic [LATENCY-1:0][1:0] c_sr_q,  c_sr_d;

    // Outputs of the delay line, aligned with enc_dout
    logic       de_dly;
    logic [1:0] c_dly;

    // Registered outputs
    logic [9:0]        tmds_q,      tmds_d;
    logic              tmds_de_q,   tmds_de_d;
    logic              align_err_q, align_err_d;
    logic [LWIDTH-1:0] line_len_q,  line_len_d;
    logic              line_done_q, line_done_d;

    // Run tracking: previous-cycle active flag and saturating run counter
    logic              de_prev_q, de_prev_d;
    logic [LWIDTH-1:0] cnt_q,     cnt_d;

    logic [9:0]        blank_tok;
    logic [LWIDTH-1:0] cnt_inc;
    logic              run_end;

    assign de_dly = de_sr_q[LATENCY-1];
    assign c_dly  = c_sr_q[LATENCY-1];

    // Delay line shifts in c/de while enabled; dropping cs flushes every stage
    always_comb begin
        de_sr_d = '0;
        c_sr_d  = '0;
        if (cs) begin
            de_sr_d[0] = de;
            c_sr_d[0]  = c;
            for (int i = 1; i < LATENCY; i++) begin
                de_sr_d[i] = de_sr_q[i-1];
                c_sr_d[i]  = c_sr_q[i-1];
            end
        end
    end

    // Control token matching the delayed control bits
    always_comb begin
        blank_tok = TOK_C00;
        case (c_dly)
            2'b00:   blank_tok = TOK_C00;
            2'b01:   blank_tok = TOK_C01;
            2'b10:   blank_tok = TOK_C10;
            2'b11:   blank_tok = TOK_C11;
            default: blank_tok = TOK_C00;
        endcase
    end

    // Output word selection: idle token when disabled, data during active video, else control token
    always_comb begin
        tmds_d    = TOK_C00;
        tmds_de_d = 1'b0;
        if (cs) begin
            tmds_d    = de_dly ? enc_dout : blank_tok;
            tmds_de_d = de_dly;
        end
    end

    // Sticky flag for encoder enable disagreeing with the delayed de; cleared only by cs=0
    always_comb begin
        align_err_d = align_err_q;
        if (!cs) begin
            align_err_d = 1'b0;
        end else if (de_dly != enc_dout_en) begin
            align_err_d = 1'b1;
        end
    end

    // Active-run length: counts enabled de_dly cycles, saturates, and reports on the falling edge.
    // cnt_q already includes the last active cycle when the edge is seen, so it is the run length.
    // de_prev_q is gated by cs so a cs drop cannot later look like a falling edge.
    always_comb begin
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        run_end     = cs & de_prev_q & ~de_dly;
        cnt_d       = (cs & de_dly) ? cnt_inc : '0;
        de_prev_d   = cs & de_dly;
        line_len_d  = run_end ? cnt_q : line_len_q;
        line_done_d = run_end;
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_sr_q     <= '0;
            c_sr_q      <= '0;
            tmds_q      <= '0;
            tmds_de_q   <= 1'b0;
            align_err_q <= 1'b0;
            line_len_q  <= '0;
            line_done_q <= 1'b0;
            de_prev_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            de_sr_q     <= de_sr_d;
            c_sr_q      <= c_sr_d;
            tmds_q      <= tmds_d;
            tmds_de_q   <= tmds_de_d;
            align_err_q <= align_err_d;
            line_len_q  <= line_len_d;
            line_done_q <= line_done_d;
            de_prev_q   <= de_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tmds      = tmds_q;
    assign tmds_de   = tmds_de_q;
    assign align_err = align_err_q;
    assign line_len  = line_len_q;
    assign line_done = line_done_q;

endmodule

// File: tb/tb_cv_tmdschan.sv
// Randomized bench for cv_tmdschan against a cycle-history reference model.
// Latency: model predicts every registered output after each clock edge.
// Backpressure: none; the bench drives one pixel per clock.
module tb_cv_tmdschan;

    localparam int L      = 3;
    localparam int LW     = 12;
    localparam int MAXLEN = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic [1:0]    c;
    logic          de;
    logic [9:0]    enc_dout;
    logic          enc_dout_en;
    logic [9:0]    tmds;
    logic          tmds_de;
    logic          align_err;
    logic [LW-1:0] line_len;
    logic          line_done;

    cv_tmdschan #(.LATENCY(L), .LWIDTH(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .c           (c),
        .de          (de),
        .enc_dout    (enc_dout),
        .enc_dout_en (enc_dout_en),
        .tmds        (tmds),
        .tmds_de     (tmds_de),
        .align_err   (align_err),
        .line_len    (line_len),
        .line_done   (line_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Per-cycle input history; a reset cycle is recorded as cs=0 (both flush the pipeline)
    bit         cs_h[$];
    bit         de_h[$];
    logic [1:0] c_h[$];

    int run      = 0;   // unbounded length of the current enabled active run
    int exp_len  = 0;
    bit exp_align = 1'b0;
    int seen_len = -1;  // line_len captured from the DUT on its latest line_done
    int n_done   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] token(input logic [1:0] cc);
        case (cc)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // de as seen L cycles later: survives only if cs stayed high through the delay
    function automatic bit dly_de(input int t);
        if (t < L) return 1'b0;
        for (int k = t - L; k < t; k++)
            if (!cs_h[k]) return 1'b0;
        return de_h[t-L];
    endfunction

    function automatic logic [1:0] dly_c(input int t);
        if (t < L) return 2'b00;
        for (int k = t - L; k < t; k++)
            if (!cs_h[k]) return 2'b00;
        return c_h[t-L];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_tmds"},  32'(tmds),      32'd0);
        check({tag, "_de"},    32'(tmds_de),   32'd0);
        check({tag, "_align"}, 32'(align_err), 32'd0);
        check({tag, "_len"},   32'(line_len),  32'd0);
        check({tag, "_done"},  32'(line_done), 32'd0);
    endtask

    // One pixel clock: drive inputs, predict, clock, compare all outputs
    task automatic drive_cycle(input bit cs_i, input bit de_i, input logic [1:0] c_i, input bit mis);
        int         t;
        bit         dd;
        logic [1:0] cd;
        logic [9:0] word;
        logic [9:0] ex_tmds;
        bit         ex_done;
        t  = cs_h.size();
        dd = dly_de(t);
        cd = dly_c(t);
        cs_h.push_back(cs_i);
        de_h.push_back(de_i);
        c_h.push_back(c_i);
        word        = 10'($urandom);
        cs          = cs_i;
        de          = de_i;
        c           = c_i;
        enc_dout    = word;
        enc_dout_en = dd ^ mis;
        ex_tmds = !cs_i ? token(2'b00) : (dd ? word : token(cd));
        ex_done = cs_i && !dd && (run > 0);
        if (ex_done) exp_len = (run > MAXLEN) ? MAXLEN : run;
        run = (cs_i && dd) ? run + 1 : 0;
        if (!cs_i) exp_align = 1'b0;
        else if (mis) exp_align = 1'b1;
        @(posedge clk);
        #1;
        check("tmds",      32'(tmds),      32'(ex_tmds));
        check("tmds_de",   32'(tmds_de),   32'(cs_i && dd));
        check("align_err", 32'(align_err), 32'(exp_align));
        check("line_len",  32'(line_len),  32'(exp_len));
        check("line_done", 32'(line_done), 32'(ex_done));
        if (line_done) begin
            n_done++;
            seen_len = int'(line_len);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset(input int ncyc);
        reset       = 1'b1;
        cs          = 1'b0;
        de          = 1'b0;
        c           = 2'b00;
        enc_dout    = '0;
        enc_dout_en = 1'b0;
        #1;
        check_zero("rst_async");
        run       = 0;
        exp_len   = 0;
        exp_align = 1'b0;
        repeat (ncyc) begin
            cs_h.push_back(1'b0);
            de_h.push_back(1'b0);
            c_h.push_back(2'b00);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        reset = 1'b0;
    endtask

    task automatic blank(input int n, input logic [1:0] cc);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, cc, 1'b0);
    endtask

    task automatic run_line(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 2'($urandom), 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        cs          = 1'b0;
        de          = 1'b0;
        c           = 2'b00;
        enc_dout    = '0;
        enc_dout_en = 1'b0;
        #2;
        do_reset(3);

        // Blanking with c=01 settles to the 01 token
        blank(12, 2'b01);
        check("blank01", 32'(tmds), 32'(10'b0010101011));

        // 640-pixel line
        n_done = 0;
        run_line(640);
        blank(8, 2'b00);
        check("len640",  32'(seen_len), 32'd640);
        check("done640", 32'(n_done),   32'd1);

        // Walk control bits through all four tokens
        for (int k = 0; k < 4; k++) begin
            blank(L + 3, 2'(k));
            check("token_walk", 32'(tmds), 32'(token(2'(k))));
        end

        // Encoder enable disagrees once inside a run, then a 1-cycle cs drop clears the flag
        for (int i = 0; i < 50; i++) drive_cycle(1'b1, 1'b1, 2'b00, i == 20);
        check("align_set", 32'(align_err), 32'd1);
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b0);
        check("align_clr", 32'(align_err), 32'd0);
        check("cs0_token", 32'(tmds), 32'(10'b1101010100));
        blank(8, 2'b10);

        // Saturation, then a single-cycle run
        run_line(5000);
        blank(6, 2'b00);
        check("len_sat", 32'(seen_len), 32'(MAXLEN));
        run_line(1);
        blank(6, 2'b00);
        check("len_one", 32'(seen_len), 32'd1);

        // cs drop at pixel 100 gives no pulse around the drop; a following 200-run reports 200
        n_done = 0;
        for (int i = 0; i < 110; i++) drive_cycle(i != 100, 1'b1, 2'b00, 1'b0);
        check("cs_drop_nopulse", 32'(n_done), 32'd0);
        run_line(90);
        blank(6, 2'b01);
        run_line(200);
        blank(6, 2'b01);
        check("len200", 32'(seen_len), 32'd200);

        // Random lines with random blanking, occasional cs drops and enable mismatches
        for (int ln = 0; ln < 40; ln++) begin
            int n;
            int nb;
            n  = $urandom_range(1, 60);
            nb = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                drive_cycle($urandom_range(0, 49) != 0, 1'b1, 2'($urandom),
                            $urandom_range(0, 99) == 0);
            for (int i = 0; i < nb; i++)
                drive_cycle($urandom_range(0, 29) != 0, 1'($urandom_range(0, 7) == 0),
                            2'($urandom), 1'b0);
        end
        blank(8, 2'b00);

        // Reset in the middle of a line, then a clean run
        run_line(30);
        do_reset(2);
        blank(10, 2'b00);
        run_line(20);
        blank(6, 2'b11);
        check("len_after_rst", 32'(seen_len), 32'd20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
